serial_frame_rx: RTL and testbench

SERIAL_FRAME_RX -- requirements
Module: serial_frame_rx

---
 rtl/serial_frame_pkg.sv | 20 ++
 rtl/serial_frame_rx_sipo.sv | 40 ++++
 rtl/serial_frame_rx.sv | 161 ++++++++++++++++
 tb/tb_serial_frame_rx.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_frame_pkg.sv
// Shared definitions for the serial frame receiver.
//   state_t    : receiver FSM states
//   START_BIT  : line level that opens a frame
//   IDLE_LEVEL : line level between frames
//   STOP_BIT   : line level that closes a frame (equal to the idle level)
package serial_frame_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } state_t;

  localparam logic START_BIT  = 1'b1;
  localparam logic IDLE_LEVEL = 1'b0;
  // The stop bit returns the line to its idle level.
  localparam logic STOP_BIT   = IDLE_LEVEL;

endpackage : serial_frame_pkg

// File: rtl/serial_frame_rx_sipo.sv
// Serial-in / parallel-out shift register, LSB-first fill.
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset, clears the register
//   i_clr      : synchronous clear
//   i_shift_en : shift i_din in when high
//   i_din      : serial input bit
//   o_q        : parallel word; the first bit shifted in ends up at bit 0
module sipo #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clr,
  input  logic              i_shift_en,
  input  logic              i_din,
  output logic [DATA_W-1:0] o_q
);

  logic [DATA_W-1:0] r_q;

  // Shift register: new bits enter at the MSB and walk down toward bit 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= '0;
    end else if (i_clr) begin
      r_q <= '0;
    end else if (i_shift_en) begin
      if (DATA_W > 1) begin
        r_q <= {i_din, r_q[DATA_W-1:1]};
      end else begin
        r_q <= i_din;
      end
    end else begin
      r_q <= r_q;
    end
  end

  assign o_q = r_q;

endmodule : sipo

// File: rtl/serial_frame_rx.sv
// Serial frame receiver.
// Frame: start bit (1), DATA_W data bits LSB first, optional even-parity bit,
// stop bit (0). The line idles at 0.
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset
//   din        : serial bitstream, one bit per clock
//   data_out   : last correctly received word
//   data_valid : one-cycle pulse when data_out takes a good frame
//   parity_err : one-cycle pulse on parity mismatch
//   frame_err  : one-cycle pulse when the stop bit was not 0
//   busy       : high while a frame is being received
module serial_frame_rx
  import serial_frame_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int PARITY_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              din,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              busy
);

  localparam int               CNT_W    = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_bit_cnt;
  logic              r_par_bad;
  logic [DATA_W-1:0] r_data_out;
  logic              r_data_valid;
  logic              r_parity_err;
  logic              r_frame_err;
  logic              r_busy;
  logic              w_shift_en;
  logic              w_sipo_clr;
  logic              w_last_bit;
  logic [DATA_W-1:0] w_word;

  sipo #(
    .DATA_W (DATA_W)
  ) u_sipo (
    .clk        (clk),
    .rst        (rst),
    .i_clr      (w_sipo_clr),
    .i_shift_en (w_shift_en),
    .i_din      (din),
    .o_q        (w_word)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state and shift-register control.
  always_comb begin
    w_state_nxt = r_state;
    w_shift_en  = 1'b0;
    w_sipo_clr  = 1'b0;
    w_last_bit  = (r_bit_cnt == LAST_BIT);
    case (r_state)
      ST_IDLE: begin
        // Keep the word clean between frames.
        w_sipo_clr = 1'b1;
        if (din == START_BIT) begin
          w_state_nxt = ST_DATA;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_DATA: begin
        w_shift_en = 1'b1;
        if (w_last_bit) begin
          if (PARITY_EN != 0) begin
            w_state_nxt = ST_PARITY;
          end else begin
            w_state_nxt = ST_STOP;
          end
        end else begin
          w_state_nxt = ST_DATA;
        end
      end
      ST_PARITY: begin
        w_state_nxt = ST_STOP;
      end
      ST_STOP: begin
        // Always back to IDLE: a bad stop bit of 1 must not start a frame.
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Bit counter, parity check and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bit_cnt    <= '0;
      r_par_bad    <= 1'b0;
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_data_valid <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      r_busy       <= (w_state_nxt != ST_IDLE);
      case (r_state)
        ST_IDLE: begin
          r_bit_cnt <= '0;
          // Stays 0 for the whole frame when there is no parity bit.
          r_par_bad <= 1'b0;
        end
        ST_DATA: begin
          if (w_last_bit) begin
            r_bit_cnt <= '0;
          end else begin
            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
          end
        end
        ST_PARITY: begin
          // Even parity: the parity bit equals the XOR of the data bits.
          r_par_bad <= (din != (^w_word));
        end
        ST_STOP: begin
          r_frame_err  <= (din != STOP_BIT);
          r_parity_err <= r_par_bad;
          if ((din == STOP_BIT) && !r_par_bad) begin
            r_data_out   <= w_word;
            r_data_valid <= 1'b1;
          end else begin
            r_data_out   <= r_data_out;
          end
        end
        default: begin
          r_bit_cnt <= '0;
        end
      endcase
    end
  end

  assign data_out   = r_data_out;
  assign data_valid = r_data_valid;
  assign parity_err = r_parity_err;
  assign frame_err  = r_frame_err;
  assign busy       = r_busy;

endmodule : serial_frame_rx

// File: tb/tb_serial_frame_rx.sv
// Scoreboard bench for serial_frame_rx: one instance with parity, one without.
module tb_serial_frame_rx;

  typedef struct {
    logic [7:0] data;
    logic       pe;
    logic       fe;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       din_a;
  logic       din_b;
  logic [7:0] data_out_a;
  logic       dv_a;
  logic       pe_a;
  logic       fe_a;
  logic       busy_a;
  logic [7:0] data_out_b;
  logic       dv_b;
  logic       pe_b;
  logic       fe_b;
  logic       busy_b;

  int         cyc = 0;
  int         n_vec = 0;
  int         n_err = 0;
  int         busy_cnt_a = 0;
  logic [7:0] exp_last_a = 8'h00;
  logic [7:0] exp_last_b = 8'h00;
  exp_t       q_a[$];
  exp_t       q_b[$];

  serial_frame_rx #(.DATA_W(8), .PARITY_EN(1)) u_dut_a (
    .clk        (clk),
    .rst        (rst),
    .din        (din_a),
    .data_out   (data_out_a),
    .data_valid (dv_a),
    .parity_err (pe_a),
    .frame_err  (fe_a),
    .busy       (busy_a)
  );

  serial_frame_rx #(.DATA_W(8), .PARITY_EN(0)) u_dut_b (
    .clk        (clk),
    .rst        (rst),
    .din        (din_b),
    .data_out   (data_out_b),
    .data_valid (dv_b),
    .parity_err (pe_b),
    .frame_err  (fe_b),
    .busy       (busy_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (obs !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Monitor for the parity instance: pops the scoreboard on any status pulse.
  always @(negedge clk) begin
    exp_t e;
    if (busy_a) busy_cnt_a = busy_cnt_a + 1;
    if (rst) begin
      exp_last_a = 8'h00;
    end else begin
      if (dv_a || pe_a || fe_a) begin
        if (q_a.size() == 0) begin
          chk("a_unexpected_pulse", {29'd0, dv_a, pe_a, fe_a}, 32'd0);
        end else begin
          e = q_a.pop_front();
          chk("a_valid", 32'(dv_a), 32'(!(e.pe || e.fe)));
          chk("a_parity_err", 32'(pe_a), 32'(e.pe));
          chk("a_frame_err", 32'(fe_a), 32'(e.fe));
          chk("a_latency", 32'(cyc), 32'(e.cyc));
          if (!(e.pe || e.fe)) exp_last_a = e.data;
        end
      end
      chk("a_data_out", 32'(data_out_a), 32'(exp_last_a));
    end
  end

  // Monitor for the no-parity instance.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      exp_last_b = 8'h00;
    end else begin
      if (dv_b || pe_b || fe_b) begin
        if (q_b.size() == 0) begin
          chk("b_unexpected_pulse", {29'd0, dv_b, pe_b, fe_b}, 32'd0);
        end else begin
          e = q_b.pop_front();
          chk("b_valid", 32'(dv_b), 32'(!e.fe));
          chk("b_parity_err", 32'(pe_b), 32'd0);
          chk("b_frame_err", 32'(fe_b), 32'(e.fe));
          chk("b_latency", 32'(cyc), 32'(e.cyc));
          if (!e.fe) exp_last_b = e.data;
        end
      end
      chk("b_data_out", 32'(data_out_b), 32'(exp_last_b));
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Start bit is sampled at the next edge; status shows 10 edges later.
  task automatic send_a(input logic [7:0] d, input logic bad_par, input logic stop_v);
    exp_t e;
    tick();
    din_a  = 1'b1;
    e.data = d;
    e.pe   = bad_par;
    e.fe   = stop_v;
    e.cyc  = cyc + 11;
    q_a.push_back(e);
    for (int i = 0; i < 8; i++) begin
      tick();
      din_a = d[i];
    end
    tick();
    din_a = (^d) ^ bad_par;
    tick();
    din_a = stop_v;
  endtask

  task automatic send_b(input logic [7:0] d, input logic stop_v);
    exp_t e;
    tick();
    din_b  = 1'b1;
    e.data = d;
    e.pe   = 1'b0;
    e.fe   = stop_v;
    e.cyc  = cyc + 10;
    q_b.push_back(e);
    for (int i = 0; i < 8; i++) begin
      tick();
      din_b = d[i];
    end
    tick();
    din_b = stop_v;
  endtask

  task automatic idle_a(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      din_a = 1'b0;
    end
  endtask

  initial begin
    int         base;
    logic [7:0] rd;
    logic       rp;
    logic       rs;
    rst   = 1'b1;
    din_a = 1'b0;
    din_b = 1'b0;
    repeat (3) tick();
    chk("rst_data_out_a", 32'(data_out_a), 32'd0);
    chk("rst_valid_a", 32'(dv_a), 32'd0);
    chk("rst_parity_err_a", 32'(pe_a), 32'd0);
    chk("rst_frame_err_a", 32'(fe_a), 32'd0);
    chk("rst_busy_a", 32'(busy_a), 32'd0);
    chk("rst_data_out_b", 32'(data_out_b), 32'd0);
    chk("rst_busy_b", 32'(busy_b), 32'd0);
    rst = 1'b0;
    idle_a(2);

    // Good frame 0xA5, busy length.
    base = busy_cnt_a;
    send_a(8'hA5, 1'b0, 1'b0);
    idle_a(4);
    chk("a_busy_len", 32'(busy_cnt_a - base), 32'd10);

    // Parity error keeps 0xA5.
    send_a(8'h01, 1'b1, 1'b0);
    idle_a(3);

    // Frame error with stop bit 1 then long idle.
    send_a(8'h3C, 1'b0, 1'b1);
    idle_a(15);
    chk("a_idle_after_frame_err", 32'(busy_a), 32'd0);

    // Both errors at once.
    send_a(8'h5A, 1'b1, 1'b1);
    idle_a(3);

    // Back-to-back good frames.
    send_a(8'h3C, 1'b0, 1'b0);
    send_a(8'hFF, 1'b0, 1'b0);
    idle_a(3);

    // Reset after 4 data bits of 0x55, then a clean 0x81.
    tick();
    din_a = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      din_a = (i % 2 == 0) ? 1'b1 : 1'b0;
    end
    tick();
    rst   = 1'b1;
    din_a = 1'b0;
    tick();
    rst = 1'b0;
    chk("a_rst_abort_busy", 32'(busy_a), 32'd0);
    chk("a_rst_abort_data", 32'(data_out_a), 32'd0);
    send_a(8'h81, 1'b0, 1'b0);
    idle_a(3);

    // Random back-to-back frames with random faults.
    for (int j = 0; j < 6; j++) begin
      rd = 8'($urandom_range(0, 255));
      rp = 1'($urandom_range(0, 3) == 0);
      rs = 1'($urandom_range(0, 3) == 0);
      send_a(rd, rp, rs);
    end
    idle_a(3);

    // No-parity instance.
    send_b(8'h80, 1'b0);
    tick();
    din_b = 1'b0;
    send_b(8'hC3, 1'b1);
    tick();
    din_b = 1'b0;
    send_b(8'h6E, 1'b0);
    send_b(8'h17, 1'b0);
    tick();
    din_b = 1'b0;

    repeat (20) tick();
    chk("a_scoreboard_drained", 32'(q_a.size()), 32'd0);
    chk("b_scoreboard_drained", 32'(q_b.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_serial_frame_rx
